// File: rtl/sram_bist_ctrl.sv
// March C- built-in self-test controller for single-port OpenRAM macros.
// Sequences 10N ops, compares read data through a latency-matched pipeline, reports fail count and first failure.
module sram_bist_ctrl #(
   parameter int unsigned ADDR_WIDTH     = 6,
   parameter int unsigned DATA_WIDTH     = 33,
   parameter int unsigned WMASK_WIDTH    = 4,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned FAIL_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic [1:0]                pattern_sel,
   output logic                      busy,
   output logic                      done,
   output logic                      pass,
   output logic [FAIL_CNT_WIDTH-1:0] fail_count,
   output logic [ADDR_WIDTH-1:0]     first_fail_addr,
   output logic [2:0]                first_fail_elem,
   output logic                      first_fail_valid,
   output logic                      sram_csb,
   output logic                      sram_web,
   output logic                      sram_spare_wen,
   output logic [WMASK_WIDTH-1:0]    sram_wmask,
   output logic [ADDR_WIDTH-1:0]     sram_addr,
   output logic [DATA_WIDTH-1:0]     sram_din,
   input  logic [DATA_WIDTH-1:0]     sram_dout
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

   function automatic logic [DATA_WIDTH-1:0] odd_mask();
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      for (int unsigned j = 0; j < DATA_WIDTH; j++) begin
         m = {m[DATA_WIDTH-2:0], ((DATA_WIDTH - 1 - j) % 2) == 1};
      end
      return m;
   endfunction

   localparam logic [DATA_WIDTH-1:0] ODD_BITS = odd_mask();

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] exp;
      logic [ADDR_WIDTH-1:0] addr;
      logic [2:0]            elem;
   } cmp_ent_t;

   state_t                    state_q, state_d;
   logic [2:0]                gen_elem_q, gen_elem_d;
   logic [ADDR_WIDTH-1:0]     gen_addr_q, gen_addr_d;
   logic                      gen_ph_q, gen_ph_d;
   logic                      last_q, last_d;
   logic [1:0]                pat_q, pat_d;
   logic [2:0]                drain_q, drain_d;

   logic                      csb_q, csb_d;
   logic                      web_q, web_d;
   logic                      spare_q, spare_d;
   logic [WMASK_WIDTH-1:0]    wmask_q, wmask_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [DATA_WIDTH-1:0]     din_q, din_d;

   // Stage 0 describes the op currently on the SRAM bus; stage READ_LATENCY lines up with sram_dout.
   logic [READ_LATENCY:0]     vld_sr_q, vld_sr_d;
   cmp_ent_t [READ_LATENCY:0] ent_sr_q, ent_sr_d;
   cmp_ent_t                  new_ent, cmp_ent;

   logic [FAIL_CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
   logic [ADDR_WIDTH-1:0]     ff_addr_q, ff_addr_d;
   logic [2:0]                ff_elem_q, ff_elem_d;
   logic                      ff_vld_q, ff_vld_d;
   logic                      pass_q, pass_d;

   logic                      two_op, down, op_rd, op_inv, op_final;
   logic [1:0]                pat_cur;
   logic [DATA_WIDTH-1:0]     bgnd, op_data;
   logic [ADDR_WIDTH-1:0]     end_addr;
   logic                      start_run, issue, mismatch;

   // Current March op decode
   always_comb begin
      two_op   = (gen_elem_q != 3'd0) && (gen_elem_q != 3'd5);
      down     = (gen_elem_q == 3'd3) || (gen_elem_q == 3'd4);
      op_rd    = 1'b1;
      op_inv   = 1'b0;
      case (gen_elem_q)
         3'd0:       op_rd = 1'b0;
         3'd1, 3'd3: begin
            op_rd  = ~gen_ph_q;
            op_inv = gen_ph_q;
         end
         3'd2, 3'd4: begin
            op_rd  = ~gen_ph_q;
            op_inv = ~gen_ph_q;
         end
         default: ;
      endcase
      pat_cur = (state_q == S_IDLE) ? pattern_sel : pat_q;
      case (pat_cur)
         2'd0:    bgnd = '0;
         2'd1:    bgnd = gen_addr_q[0] ? ~ODD_BITS : ODD_BITS;
         2'd2:    bgnd = ODD_BITS;
         default: bgnd = {DATA_WIDTH{gen_addr_q[0]}};
      endcase
      op_data  = op_inv ? ~bgnd : bgnd;
      end_addr = down ? '0 : ADDR_MAX;
      op_final = (gen_elem_q == 3'd5) && (gen_addr_q == ADDR_MAX);
   end

   // FSM next state and status outputs
   always_comb begin
      state_d   = state_q;
      drain_d   = 3'd0;
      busy      = 1'b0;
      done      = 1'b0;
      start_run = 1'b0;
      issue     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d   = S_RUN;
               start_run = 1'b1;
               issue     = 1'b1;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (last_q) begin
               state_d = S_DRAIN;
            end else begin
               issue = !abort;
            end
         end
         S_DRAIN: begin
            busy    = 1'b1;
            drain_d = drain_q + 3'd1;
            if (drain_q == 3'(READ_LATENCY - 1)) begin
               state_d = S_DONE;
            end
         end
         default: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
      if (abort) begin
         state_d = S_IDLE;
      end
   end

   // Address/element generator and SRAM port
   always_comb begin
      gen_elem_d = gen_elem_q;
      gen_addr_d = gen_addr_q;
      gen_ph_d   = gen_ph_q;
      last_d     = last_q;
      pat_d      = start_run ? pattern_sel : pat_q;
      csb_d      = 1'b1;
      web_d      = 1'b1;
      spare_d    = 1'b0;
      wmask_d    = '0;
      addr_d     = '0;
      din_d      = '0;
      if (issue) begin
         csb_d   = 1'b0;
         web_d   = op_rd;
         spare_d = ~op_rd;
         wmask_d = op_rd ? '0 : '1;
         addr_d  = gen_addr_q;
         din_d   = op_rd ? '0 : op_data;
         last_d  = op_final;
         if (two_op && !gen_ph_q) begin
            gen_ph_d = 1'b1;
         end else begin
            gen_ph_d = 1'b0;
            if (gen_addr_q == end_addr) begin
               gen_elem_d = gen_elem_q + 3'd1;
               gen_addr_d = ((gen_elem_q == 3'd2) || (gen_elem_q == 3'd3)) ? ADDR_MAX : '0;
            end else begin
               gen_addr_d = down ? gen_addr_q - ADDR_WIDTH'(1) : gen_addr_q + ADDR_WIDTH'(1);
            end
         end
      end else if (state_d != S_RUN) begin
         gen_elem_d = 3'd0;
         gen_addr_d = '0;
         gen_ph_d   = 1'b0;
         last_d     = 1'b0;
      end
   end

   // Compare pipeline and result capture
   always_comb begin
      new_ent.exp  = op_data;
      new_ent.addr = gen_addr_q;
      new_ent.elem = gen_elem_q;
      vld_sr_d     = abort ? '0 : {vld_sr_q[READ_LATENCY-1:0], issue && op_rd};
      ent_sr_d     = {ent_sr_q[READ_LATENCY-1:0], new_ent};
      cmp_ent      = ent_sr_q[READ_LATENCY];
      mismatch     = vld_sr_q[READ_LATENCY] && !abort && (sram_dout != cmp_ent.exp);
      fail_cnt_d   = fail_cnt_q;
      ff_addr_d    = ff_addr_q;
      ff_elem_d    = ff_elem_q;
      ff_vld_d     = ff_vld_q;
      pass_d       = pass_q;
      if (start_run) begin
         fail_cnt_d = '0;
         ff_addr_d  = '0;
         ff_elem_d  = 3'd0;
         ff_vld_d   = 1'b0;
      end else if (mismatch) begin
         if (fail_cnt_q != '1) begin
            fail_cnt_d = fail_cnt_q + FAIL_CNT_WIDTH'(1);
         end
         if (!ff_vld_q) begin
            ff_addr_d = cmp_ent.addr;
            ff_elem_d = cmp_ent.elem;
            ff_vld_d  = 1'b1;
         end
      end
      if (start_run || abort) begin
         pass_d = 1'b0;
      end else if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
         pass_d = (fail_cnt_d == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         gen_elem_q <= 3'd0;
         gen_addr_q <= '0;
         gen_ph_q   <= 1'b0;
         last_q     <= 1'b0;
         pat_q      <= 2'd0;
         drain_q    <= 3'd0;
         csb_q      <= 1'b1;
         web_q      <= 1'b1;
         spare_q    <= 1'b0;
         wmask_q    <= '0;
         addr_q     <= '0;
         din_q      <= '0;
         vld_sr_q   <= '0;
         ent_sr_q   <= '0;
         fail_cnt_q <= '0;
         ff_addr_q  <= '0;
         ff_elem_q  <= 3'd0;
         ff_vld_q   <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gen_elem_q <= gen_elem_d;
         gen_addr_q <= gen_addr_d;
         gen_ph_q   <= gen_ph_d;
         last_q     <= last_d;
         pat_q      <= pat_d;
         drain_q    <= drain_d;
         csb_q      <= csb_d;
         web_q      <= web_d;
         spare_q    <= spare_d;
         wmask_q    <= wmask_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         vld_sr_q   <= vld_sr_d;
         ent_sr_q   <= ent_sr_d;
         fail_cnt_q <= fail_cnt_d;
         ff_addr_q  <= ff_addr_d;
         ff_elem_q  <= ff_elem_d;
         ff_vld_q   <= ff_vld_d;
         pass_q     <= pass_d;
      end
   end

   assign pass             = pass_q;
   assign fail_count       = fail_cnt_q;
   assign first_fail_addr  = ff_addr_q;
   assign first_fail_elem  = ff_elem_q;
   assign first_fail_valid = ff_vld_q;
   assign sram_csb         = csb_q;
   assign sram_web         = web_q;
   assign sram_spare_wen   = spare_q;
   assign sram_wmask       = wmask_q;
   assign sram_addr        = addr_q;
   assign sram_din         = din_q;

endmodule
